// File: rtl/std_pulse_stretcher_pkg.sv
// Shared types and helpers for the pulse stretcher.
package std_pulse_stretcher_pkg;

  // Per-channel phase: idle, driving the level, or enforcing the guard time.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  // Widest counter this helper handles; callers cast to their own width.
  localparam int CNT_MAX_W = 32;

  // A programmed high time of 0 still produces a one-cycle pulse.
  function automatic logic [CNT_MAX_W-1:0] clamp_min1(input logic [CNT_MAX_W-1:0] v);
    return (v == '0) ? {{(CNT_MAX_W-1){1'b0}}, 1'b1} : v;
  endfunction

endpackage

// File: rtl/std_pulse_stretcher_channel.sv
// One pulse-stretcher channel: IDLE/HIGH/GAP FSM, down-counter, registered outputs.
// Build option: STD_PULSE_STRETCHER_RETRIGGER_EN lets a trigger in HIGH
// extend the pulse instead of being dropped.
module std_pulse_stretcher_channel
  import std_pulse_stretcher_pkg::*;
#(
  parameter int COUNTER_WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clear_i,
  input  logic                     trigger_i,
  input  logic [COUNTER_WIDTH-1:0] high_cycles_i,
  input  logic [COUNTER_WIDTH-1:0] low_cycles_i,
  output logic                     level_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     dropped_o
);

  localparam logic [COUNTER_WIDTH-1:0] ONE = {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};

  state_e                   state_q, state_d;
  logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
  logic [COUNTER_WIDTH-1:0] low_q, low_d;
  logic                     level_q, busy_q, done_q, dropped_q;
  logic                     done_d, dropped_d;
  logic [COUNTER_WIDTH-1:0] h_eff, h_load;

  // H is consumed at load time (counter = H'-1), so only L needs a latched copy.
  assign h_eff  = COUNTER_WIDTH'(clamp_min1(CNT_MAX_W'(high_cycles_i)));
  assign h_load = h_eff - ONE;

  // Next-state, counter and output-pulse logic; clear overrides everything.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    low_d     = low_q;
    done_d    = 1'b0;
    dropped_d = 1'b0;
    if (clear_i) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (trigger_i) begin
            state_d = ST_HIGH;
            cnt_d   = h_load;
            low_d   = low_cycles_i;
          end
        end
        ST_HIGH: begin
`ifdef STD_PULSE_STRETCHER_RETRIGGER_EN
          // Retrigger restarts the high time from this cycle; done is deferred.
          if (trigger_i) begin
            cnt_d = h_load;
            low_d = low_cycles_i;
          end else
`else
          dropped_d = trigger_i;
`endif
          if (cnt_q != '0) begin
            cnt_d = cnt_q - ONE;
          end else begin
            done_d = 1'b1;
            if (low_q == '0) begin
              state_d = ST_IDLE;
              cnt_d   = '0;
            end else begin
              state_d = ST_GAP;
              cnt_d   = low_q - ONE;
            end
          end
        end
        ST_GAP: begin
          // Guard time is never shortened or extended by triggers.
          dropped_d = trigger_i;
          if (cnt_q == '0) state_d = ST_IDLE;
          else             cnt_d   = cnt_q - ONE;
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State, counter and latched guard time.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      low_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      low_q   <= low_d;
    end
  end

  // Outputs registered from next state so they align with the state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      level_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      level_q   <= (state_d == ST_HIGH);
      busy_q    <= (state_d != ST_IDLE);
      done_q    <= done_d;
      dropped_q <= dropped_d;
    end
  end

  assign level_o   = level_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign dropped_o = dropped_q;

endmodule

// File: rtl/std_pulse_stretcher.sv
// Multi-channel pulse stretcher: WIDTH independent channels sharing H/L config
// and clear. Build option: STD_PULSE_STRETCHER_RETRIGGER_EN (see channel).
module std_pulse_stretcher
  import std_pulse_stretcher_pkg::*;
#(
  parameter int WIDTH         = 1,
  parameter int COUNTER_WIDTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_clear,
  input  logic [WIDTH-1:0]         i_trigger,
  input  logic [COUNTER_WIDTH-1:0] i_high_cycles,
  input  logic [COUNTER_WIDTH-1:0] i_low_cycles,
  output logic [WIDTH-1:0]         o_level,
  output logic [WIDTH-1:0]         o_busy,
  output logic [WIDTH-1:0]         o_done,
  output logic [WIDTH-1:0]         o_dropped
);

  for (genvar g = 0; g < WIDTH; g++) begin : g_ch
    std_pulse_stretcher_channel #(
      .COUNTER_WIDTH(COUNTER_WIDTH)
    ) u_ch (
      .clk_i        (i_clk),
      .rst_ni       (i_rst),
      .clear_i      (i_clear),
      .trigger_i    (i_trigger[g]),
      .high_cycles_i(i_high_cycles),
      .low_cycles_i (i_low_cycles),
      .level_o      (o_level[g]),
      .busy_o       (o_busy[g]),
      .done_o       (o_done[g]),
      .dropped_o    (o_dropped[g])
    );
  end

endmodule

// File: tb/tb_std_pulse_stretcher.sv
// Scoreboard bench: a timing-window model predicts each output cycle when the
// stimulus is driven; the prediction is queued and checked one cycle later.
module tb_std_pulse_stretcher;

  localparam int W  = 2;
  localparam int CW = 8;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b0;
  logic          i_clear = 1'b0;
  logic [W-1:0]  i_trigger = '0;
  logic [CW-1:0] i_high_cycles = '0;
  logic [CW-1:0] i_low_cycles = '0;
  logic [W-1:0]  o_level, o_busy, o_done, o_dropped;

  std_pulse_stretcher #(.WIDTH(W), .COUNTER_WIDTH(CW)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_clear      (i_clear),
    .i_trigger    (i_trigger),
    .i_high_cycles(i_high_cycles),
    .i_low_cycles (i_low_cycles),
    .o_level      (o_level),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_dropped    (o_dropped)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int           cyc;
    logic [W-1:0] lvl, bsy, dn, dr;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;

  // Model: per channel, first/last HIGH cycle, last busy cycle, done and drop cycles.
  int hs[W], he[W], be[W], dn_at[W], dr_at[W];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, act, expv);
    end
  endtask

  task automatic model_reset();
    for (int n = 0; n < W; n++) begin
      hs[n] = -1; he[n] = -1; be[n] = -1; dn_at[n] = -1; dr_at[n] = -1;
    end
  endtask

  task automatic model_step(input logic [W-1:0] trg, input logic clr);
    int hp, l, t;
    t  = cyc;
    hp = (i_high_cycles == 0) ? 1 : int'(i_high_cycles);
    l  = int'(i_low_cycles);
    if (clr) begin
      model_reset();
    end else begin
      for (int n = 0; n < W; n++) begin
        if (trg[n]) begin
          if (t > be[n]) begin
            hs[n] = t + 1; he[n] = t + hp; be[n] = he[n] + l; dn_at[n] = he[n] + 1;
          end else if (t >= hs[n] && t <= he[n]) begin
`ifdef STD_PULSE_STRETCHER_RETRIGGER_EN
            he[n] = t + hp; be[n] = he[n] + l; dn_at[n] = he[n] + 1;
`else
            dr_at[n] = t + 1;
`endif
          end else begin
            dr_at[n] = t + 1;
          end
        end
      end
    end
  endtask

  function automatic exp_t model_out(input int x);
    exp_t e;
    e.cyc = x;
    for (int n = 0; n < W; n++) begin
      e.lvl[n] = (x >= hs[n] && x <= he[n]);
      e.bsy[n] = (x >= hs[n] && x <= be[n]);
      e.dn[n]  = (x == dn_at[n]);
      e.dr[n]  = (x == dr_at[n]);
    end
    return e;
  endfunction

  // Drive one cycle of stimulus (called at negedge), predict, then check.
  task automatic tick(input logic [W-1:0] trg, input logic clr);
    exp_t e;
    i_trigger = trg;
    i_clear   = clr;
    model_step(trg, clr);
    exp_q.push_back(model_out(cyc + 1));
    @(posedge i_clk);
    cyc++;
    @(negedge i_clk);
    i_trigger = '0;
    i_clear   = 1'b0;
    e = exp_q.pop_front();
    chk("level",   32'(o_level),   32'(e.lvl));
    chk("busy",    32'(o_busy),    32'(e.bsy));
    chk("done",    32'(o_done),    32'(e.dn));
    chk("dropped", 32'(o_dropped), 32'(e.dr));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick('0, 1'b0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, 32'({o_level, o_busy, o_done, o_dropped}), 32'd0);
  endtask

  initial begin
    model_reset();
    // Reset state
    repeat (2) @(negedge i_clk);
    chk_all_zero("reset_outs");
    i_rst = 1'b1;
    idle(3);

    // Basic pulse H=3 L=2, then trigger in first idle cycle; config change mid-pulse ignored
    i_high_cycles = 8'd3; i_low_cycles = 8'd2;
    tick(2'b01, 1'b0);
    idle(5);
    tick(2'b01, 1'b0);
    i_high_cycles = 8'd7; i_low_cycles = 8'd0;
    idle(3);
    i_high_cycles = 8'd3; i_low_cycles = 8'd2;
    idle(8);

    // H=0 clamp, L=0: every 2 cycles all accepted, every cycle alternates
    i_high_cycles = 8'd0; i_low_cycles = 8'd0;
    for (int i = 0; i < 4; i++) begin tick(2'b11, 1'b0); tick('0, 1'b0); end
    for (int i = 0; i < 6; i++) tick(2'b01, 1'b0);
    idle(3);

    // Drop in GAP: H=2 L=4, second trigger 4 cycles later lands in GAP
    i_high_cycles = 8'd2; i_low_cycles = 8'd4;
    tick(2'b01, 1'b0);
    idle(3);
    tick(2'b01, 1'b0);
    idle(8);

    // Trigger in HIGH: H=4, triggers 2 cycles apart
    i_high_cycles = 8'd4; i_low_cycles = 8'd1;
    tick(2'b10, 1'b0);
    tick('0, 1'b0);
    tick(2'b10, 1'b0);
    idle(10);

    // Clear priority with simultaneous trigger mid-pulse, then fresh pulse
    i_high_cycles = 8'd5; i_low_cycles = 8'd2;
    tick(2'b11, 1'b0);
    tick('0, 1'b0);
    tick(2'b11, 1'b1);
    tick(2'b01, 1'b0);
    idle(10);

    // Async reset with ch0 in HIGH and ch1 in GAP
    i_high_cycles = 8'd2; i_low_cycles = 8'd6;
    tick(2'b10, 1'b0);
    idle(2);
    tick(2'b01, 1'b0);
    #2 i_rst = 1'b0;
    #1 chk_all_zero("async_rst_outs");
    model_reset();
    #1 i_rst = 1'b1;
    @(negedge i_clk);
    cyc++;
    chk_all_zero("post_rst_outs");
    // Independent channels triggered on different cycles
    i_high_cycles = 8'd3; i_low_cycles = 8'd1;
    tick(2'b01, 1'b0);
    tick('0, 1'b0);
    tick(2'b10, 1'b0);
    idle(8);

    // Maximum high time
    i_high_cycles = 8'd255; i_low_cycles = 8'd0;
    tick(2'b01, 1'b0);
    idle(258);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      if (i % 50 == 0) begin
        i_high_cycles = CW'($urandom_range(0, 5));
        i_low_cycles  = CW'($urandom_range(0, 4));
      end
      tick(W'($urandom_range(0, 3)), ($urandom_range(0, 40) == 0));
    end
    idle(12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
